fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, decode-side
// instruction handshake and branch redirect operands.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic        target_sel;
  logic [31:0] redirect_base;
  logic [31:0] rs1;
  logic [31:0] immext;
  logic        misalign;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, misalign,
    input  imem_rvalid, imem_rdata, instr_ready, redirect, target_sel,
           redirect_base, rs1, immext
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, misalign,
    output imem_rvalid, imem_rdata, instr_ready, redirect, target_sel,
           redirect_base, rs1, immext
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher feeding a 2-entry {word, pc} buffer,
// with branch redirect, in-flight discard and sticky misaligned-target halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);
  // state   | meaning
  // IDLE    | no fetch outstanding; may issue when buffer has room
  // WAIT    | one fetch outstanding, its word will be buffered
  // DISCARD | one fetch outstanding, its word belongs to a flushed stream
  // HALT    | misaligned redirect seen; frozen until reset
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD, HALT} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state;
  logic [31:0] fpc;
  logic [31:0] req_pc;
  logic [31:0] word0, word1;
  logic [31:0] pc0, pc1;
  logic [1:0]  count;
  logic        misalign_q;

  logic [31:0] target;
  logic        target_ok;
  logic        valid;
  logic        fire;
  logic        push;
  logic        pop;

  always_comb begin
    target = 32'h0;
    if (bus.target_sel)
      target = (bus.rs1 + bus.immext) & ~32'h1;
    else
      target = bus.redirect_base + bus.immext;
  end

  assign target_ok = (target[1:0] == 2'b00);
  assign valid     = (count != 2'd0) && (state != HALT);
  assign fire      = rst && (state == IDLE) && (count < 2'd2) && !bus.redirect;
  assign push      = (state == WAIT) && bus.imem_rvalid;
  assign pop       = valid && bus.instr_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      fpc        <= RESET_PC;
      req_pc     <= RESET_PC;
      count      <= 2'd0;
      misalign_q <= 1'b0;
    end else if (state != HALT) begin
      if (bus.redirect) begin
        count <= 2'd0;
        if (!target_ok) begin
          misalign_q <= 1'b1;
          state      <= HALT;
        end else begin
          fpc <= target;
          // A response landing in the redirect cycle is the stale word itself,
          // so nothing remains to discard afterwards.
          case (state)
            WAIT, DISCARD: state <= bus.imem_rvalid ? IDLE : DISCARD;
            default:       state <= IDLE;
          endcase
        end
      end else begin
        case (state)
          IDLE: begin
            if (fire) begin
              req_pc <= fpc;
              fpc    <= fpc + 32'd4;
              state  <= WAIT;
            end
          end
          WAIT:    if (bus.imem_rvalid) state <= IDLE;
          DISCARD: if (bus.imem_rvalid) state <= IDLE;
          default: state <= state;
        endcase

        // Issue rule guarantees a free slot whenever a push arrives.
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              word0 <= bus.imem_rdata;
              pc0   <= req_pc;
            end else begin
              word1 <= bus.imem_rdata;
              pc1   <= req_pc;
            end
            count <= count + 2'd1;
          end
          2'b01: begin
            word0 <= word1;
            pc0   <= pc1;
            count <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              word0 <= bus.imem_rdata;
              pc0   <= req_pc;
            end else begin
              word0 <= word1;
              pc0   <= pc1;
              word1 <= bus.imem_rdata;
              pc1   <= req_pc;
            end
          end
          default: count <= count;
        endcase
      end
    end
  end

  assign bus.imem_req    = fire;
  assign bus.imem_addr   = fpc;
  assign bus.instr_valid = valid;
  assign bus.instr       = valid ? word0 : NOP;
  assign bus.instr_pc    = valid ? pc0 : 32'h0;
  assign bus.misalign    = misalign_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order memory model with 1..3 cycle latency,
// instruction-stream reference model and a decoupled output monitor.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready, redirect, sel;
  logic [31:0] base, rs1v, imm;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fixed_lat = 1;
  int last_due  = 0;
  int acc   = 0;
  bit halted = 1'b0;

  mreq_t       mq[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] exp_q[$];
  logic [31:0] next_exp = RESET_PC;

  always #5 clk = ~clk;

  fetch_unit_if bus();
  assign bus.imem_rvalid   = mem_rvalid;
  assign bus.imem_rdata    = mem_rdata;
  assign bus.instr_ready   = ready;
  assign bus.redirect      = redirect;
  assign bus.target_sel    = sel;
  assign bus.redirect_base = base;
  assign bus.rs1           = rs1v;
  assign bus.immext        = imm;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F2E};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory: answers each request in order after its latency, also while in reset
  initial begin : memory
    int    lat;
    int    due;
    mreq_t m;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
      #2;
      if (bus.imem_req) begin
        lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        m.addr = bus.imem_addr;
        m.due  = due;
        mq.push_back(m);
        req_log.push_back(bus.imem_addr);
        req_cyc.push_back(cyc);
      end
    end
  end

  // reference model: the consumer must see consecutive words of the current stream
  initial begin : model
    logic [31:0] t;
    forever begin
      @(posedge clk);
      if (!rst) begin
        exp_q.delete();
        next_exp = RESET_PC;
        halted   = 1'b0;
      end else if (redirect && !halted) begin
        t = sel ? ((rs1v + imm) & 32'hFFFF_FFFE) : (base + imm);
        exp_q.delete();
        if (t[1:0] != 2'b00) halted = 1'b1;
        else next_exp = t;
      end
      if (rst && !halted)
        while (exp_q.size() < 4) begin
          exp_q.push_back(next_exp);
          next_exp = next_exp + 32'd4;
        end
    end
  end

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        if (halted) begin
          check("halt_req", 32'(bus.imem_req), 32'd0);
          check("halt_valid", 32'(bus.instr_valid), 32'd0);
          check("halt_misalign", 32'(bus.misalign), 32'd1);
        end else if (bus.instr_valid) begin
          if (ready) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_instr: got pc %h expected none", bus.instr_pc);
            end else begin
              e = exp_q.pop_front();
              check("instr_pc", bus.instr_pc, e);
              check("instr_word", bus.instr, mem_word(e));
              acc++;
            end
          end
        end else begin
          check("empty_instr", bus.instr, NOP);
          check("empty_pc", bus.instr_pc, 32'h0);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    redirect = 1'b0;
    repeat (4) @(negedge clk);
    req_log.delete();
    req_cyc.delete();
    rst = 1'b1;
  endtask

  task automatic wait_reqs(input int n, input int limit, input string name, output bit ok);
    int k;
    k = 0;
    while (req_log.size() < n && k < limit) begin
      @(negedge clk);
      #3;
      k++;
    end
    ok = (req_log.size() >= n);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, requests %0d expected %0d", name, req_log.size(), n);
    end
  endtask

  task automatic wait_acc(input int target_acc, input int limit, input string name);
    int k;
    k = 0;
    while (acc < target_acc && k < limit) begin
      @(negedge clk);
      #3;
      k++;
    end
    check(name, 32'(acc >= target_acc), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit          ok;
    int          first_v;
    int          idx;
    int          acc0;
    logic [31:0] t;
    rst = 1'b0; ready = 1'b1; redirect = 1'b0; sel = 1'b0;
    base = 32'h0; rs1v = 32'h0; imm = 32'h0;

    // reset state
    repeat (3) @(negedge clk);
    #3;
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", bus.instr, NOP);
    check("rst_pc", bus.instr_pc, 32'h0);
    check("rst_misalign", 32'(bus.misalign), 32'd0);

    // release, 1-cycle memory, consumer always ready
    @(negedge clk);
    req_log.delete();
    req_cyc.delete();
    rst = 1'b1;
    #3;
    check("first_req", 32'(bus.imem_req), 32'd1);
    check("first_addr", bus.imem_addr, RESET_PC);
    first_v = -1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #3;
      end
      if (bus.instr_valid && first_v < 0) first_v = k;
    end
    check("first_valid_cycle", 32'(first_v), 32'd2);
    if (req_log.size() >= 3) begin
      check("seq_addr0", req_log[0], 32'h0);
      check("seq_addr1", req_log[1], 32'h4);
      check("seq_addr2", req_log[2], 32'h8);
      check("seq_gap", 32'(req_cyc[1] - req_cyc[0]), 32'd2);
    end else begin
      total++;
      bad++;
      $display("FAIL seq_reqs: got %0d requests expected 3", req_log.size());
    end

    // consumer stalled: buffer fills after two fetches
    ready = 1'b0;
    do_reset();
    repeat (9) @(negedge clk);
    #3;
    check("stall_reqs", 32'(req_log.size()), 32'd2);
    check("stall_req_low", 32'(bus.imem_req), 32'd0);
    check("stall_valid", 32'(bus.instr_valid), 32'd1);
    @(negedge clk);
    ready = 1'b1;
    wait_reqs(3, 10, "resume_wait", ok);
    if (ok) check("resume_addr", req_log[2], 32'h8);

    // redirect while a slow fetch is in flight
    fixed_lat = 3;
    do_reset();
    @(negedge clk);
    redirect = 1'b1; sel = 1'b0; base = 32'h100; imm = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect = 1'b0;
    wait_reqs(2, 10, "redir_wait", ok);
    if (ok) check("redir_addr", req_log[1], 32'hF8);
    acc0 = acc;
    wait_acc(acc0 + 2, 20, "redir_progress");

    // fetch address wraps past the top of memory
    fixed_lat = 1;
    @(negedge clk);
    redirect = 1'b1; sel = 1'b0; base = 32'hFFFF_FFF0; imm = 32'hC;
    #3;
    idx = req_log.size();
    @(negedge clk);
    redirect = 1'b0;
    wait_reqs(idx + 2, 20, "wrap_wait", ok);
    if (ok) begin
      check("wrap_top", req_log[idx], 32'hFFFF_FFFC);
      check("wrap_zero", req_log[idx + 1], 32'h0);
    end

    // randomized traffic: latency, backpressure and aligned redirects
    fixed_lat = 0;
    acc0 = acc;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      ready    = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 15) == 0);
      if (redirect) begin
        sel  = 1'($urandom_range(0, 1));
        base = $urandom & 32'hFFFF_FFFC;
        rs1v = $urandom;
        imm  = $urandom;
        if (!sel) imm = imm & 32'hFFFF_FFFC;
        else begin
          t = (rs1v + imm) & 32'hFFFF_FFFE;
          if (t[1]) imm = imm + 32'd2;
        end
      end
    end
    @(negedge clk);
    redirect = 1'b0;
    ready    = 1'b1;
    check("random_progress", 32'(acc - acc0 > 100), 32'd1);

    // misaligned target halts until reset, later redirects ignored
    @(negedge clk);
    redirect = 1'b1; sel = 1'b1; rs1v = 32'h203; imm = 32'h0;
    @(negedge clk);
    redirect = 1'b0;
    repeat (3) @(negedge clk);
    redirect = 1'b1; sel = 1'b0; base = 32'h40; imm = 32'h0;
    @(negedge clk);
    redirect = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("mis_flag", 32'(bus.misalign), 32'd1);
    check("mis_req", 32'(bus.imem_req), 32'd0);
    check("mis_valid", 32'(bus.instr_valid), 32'd0);

    // reset mid-fetch with the late response arriving during reset
    fixed_lat = 3;
    do_reset();
    #3;
    check("rst2_misalign", 32'(bus.misalign), 32'd0);
    check("rst2_req", 32'(bus.imem_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("midrst_req", 32'(bus.imem_req), 32'd0);
    repeat (4) @(negedge clk);
    req_log.delete();
    req_cyc.delete();
    acc0 = acc;
    rst = 1'b1;
    #3;
    check("rel_req", 32'(bus.imem_req), 32'd1);
    check("rel_addr", bus.imem_addr, RESET_PC);
    wait_acc(acc0 + 1, 20, "rel_first_output");

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
